// File: rtl/sfm_acc_den_inverter_nr.sv
// Multi-lane reciprocal: quadratic mantissa seed refined by Newton-Raphson
// iterations on one truncating fixed-point multiplier per lane, lockstep FSM.
module sfm_acc_den_inverter_nr #(
   // fpnew format encoding: 0 FP32 (accumulator format), 1 FP64, 2 FP16, 3 FP8, 4 FP16ALT
   parameter int unsigned FPFORMAT    = 0,
   parameter int unsigned NUM_LANES   = 1,
   parameter int unsigned N_SEED_BITS = 8,
   parameter int unsigned NUM_ITER    = 4,
   parameter int unsigned GUARD_BITS  = 4,
   localparam int unsigned EXP_BITS = (FPFORMAT == 1) ? 11 :
                                      ((FPFORMAT == 2) || (FPFORMAT == 3)) ? 5 : 8,
   localparam int unsigned MAN_BITS = (FPFORMAT == 1) ? 52 :
                                      (FPFORMAT == 2) ? 10 :
                                      (FPFORMAT == 3) ? 2  :
                                      (FPFORMAT == 4) ? 7  : 23,
   localparam int unsigned WIDTH    = 1 + EXP_BITS + MAN_BITS
) (
   input  logic                       clk_i,
   input  logic                       rst_i,
   input  logic                       clear_i,
   input  logic                       valid_i,
   output logic                       ready_o,
   input  logic [NUM_LANES*WIDTH-1:0] den_i,
   output logic                       valid_o,
   input  logic                       ready_i,
   output logic [NUM_LANES*WIDTH-1:0] inv_o
);

   localparam int unsigned IW = MAN_BITS + GUARD_BITS;
   localparam int unsigned FW = IW + 2;
   localparam int unsigned NS = N_SEED_BITS;
   localparam logic [2:0]          LAST_ITER = 3'((NUM_ITER > 0) ? NUM_ITER - 1 : 0);
   localparam logic [EXP_BITS+1:0] TWO_BIAS  = {2'b00, {(EXP_BITS-1){1'b1}}, 1'b0};
   localparam logic [FW-1:0]       ONE       = {2'b01, {IW{1'b0}}};
   localparam logic [FW-1:0]       TWO       = {2'b10, {IW{1'b0}}};
   localparam logic [FW-1:0]       HALF      = {3'b001, {(IW-1){1'b0}}};

   typedef enum logic [2:0] {IDLE, SEED, MUL_T, MUL_Y, DONE} state_e;

   state_e     state_q, state_d;
   logic [2:0] iter_q, iter_d;
   logic       accept;
   logic       load_out;

   always_ff @(posedge clk_i or posedge rst_i) begin
      if (rst_i) begin
         state_q <= IDLE;
         iter_q  <= '0;
      end else begin
         state_q <= state_d;
         iter_q  <= iter_d;
      end
   end

   always_comb begin
      state_d = state_q;
      iter_d  = iter_q;
      case (state_q)
         IDLE: if (valid_i) state_d = SEED;
         SEED: begin
            iter_d = '0;
            if (NUM_ITER > 0) state_d = MUL_T;
            else              state_d = DONE;
         end
         MUL_T: state_d = MUL_Y;
         MUL_Y: begin
            if (iter_q == LAST_ITER) begin
               state_d = DONE;
            end else begin
               iter_d  = iter_q + 3'd1;
               state_d = MUL_T;
            end
         end
         DONE: if (ready_i) state_d = IDLE;
         default: state_d = IDLE;
      endcase
      if (clear_i) begin
         state_d = IDLE;
         iter_d  = '0;
      end
   end

   assign ready_o  = (state_q == IDLE);
   assign valid_o  = (state_q == DONE);
   assign accept   = (state_q == IDLE) && valid_i && !clear_i;
   assign load_out = (state_d == DONE) && (state_q != DONE);

   for (genvar k = 0; k < NUM_LANES; k++) begin : g_lane
      logic [WIDTH-1:0]    den;
      logic [EXP_BITS-1:0] den_exp;
      logic [MAN_BITS-1:0] den_man;
      logic                sign_q, nan_q, inf_q, zero_q;
      logic [EXP_BITS-1:0] exp_q;
      logic [MAN_BITS-1:0] man_q;
      logic [FW-1:0]       y_q, y_d, t_q, t_d;
      logic [WIDTH-1:0]    inv_q, inv_d;
      logic [NS-1:0]       s, n, n_half, f;
      logic [2*NS-1:0]     p;
      logic [FW-1:0]       x, y_seed, mul_a, mul_b, mres;
      logic [2*FW-1:0]     prod;
      logic                ge1, uf;
      logic [EXP_BITS+1:0] e_res;

      assign den     = den_i[k*WIDTH +: WIDTH];
      assign den_exp = den[WIDTH-2 -: EXP_BITS];
      assign den_man = den[MAN_BITS-1:0];

      always_ff @(posedge clk_i or posedge rst_i) begin
         if (rst_i) begin
            sign_q <= 1'b0;
            nan_q  <= 1'b0;
            inf_q  <= 1'b0;
            zero_q <= 1'b0;
            exp_q  <= '0;
            man_q  <= '0;
            y_q    <= '0;
            t_q    <= '0;
            inv_q  <= '0;
         end else begin
            if (accept) begin
               sign_q <= den[WIDTH-1];
               exp_q  <= den_exp;
               man_q  <= den_man;
               zero_q <= (den_exp == '0);
               inf_q  <= (den_exp == '1) && (den_man == '0);
               nan_q  <= (den_exp == '1) && (den_man != '0);
            end
            y_q   <= y_d;
            t_q   <= t_d;
            inv_q <= inv_d;
         end
      end

      always_comb begin
         // Seed 0.5*(1 + (1-m)^2) from the top mantissa bits; exact 1.0 when they are zero.
         s      = man_q[MAN_BITS-1 -: NS];
         n      = ~s;
         n_half = n >> 1;
         p      = {{NS{1'b0}}, n_half} * {{NS{1'b0}}, n};
         f      = NS'(p >> (NS - 1));
         y_seed = (s == '0) ? ONE : FW'(HALF + (FW'(f) << (IW - 1 - NS)));

         x     = {2'b01, man_q, {GUARD_BITS{1'b0}}};
         mul_a = (state_q == MUL_T) ? x   : y_q;
         mul_b = (state_q == MUL_T) ? y_q : FW'(TWO - t_q);
         prod  = {{FW{1'b0}}, mul_a} * {{FW{1'b0}}, mul_b};
         mres  = FW'(prod >> IW);

         y_d   = y_q;
         t_d   = t_q;
         inv_d = inv_q;
         case (state_q)
            SEED:    y_d = y_seed;
            MUL_T:   t_d = mres;
            MUL_Y:   y_d = mres;
            default: ;
         endcase

         // y below 1.0 is renormalised by one bit, which costs one exponent step.
         ge1   = y_d[IW+1] | y_d[IW];
         e_res = TWO_BIAS - {2'b00, exp_q} - {{(EXP_BITS+1){1'b0}}, ~ge1};
         uf    = e_res[EXP_BITS+1] | (e_res == '0);

         if (load_out) begin
            if (nan_q)
               inv_d = {1'b0, {EXP_BITS{1'b1}}, 1'b1, {(MAN_BITS-1){1'b0}}};
            else if (zero_q)
               inv_d = {sign_q, {EXP_BITS{1'b1}}, {MAN_BITS{1'b0}}};
            else if (inf_q || uf)
               inv_d = {sign_q, {(WIDTH-1){1'b0}}};
            else if (ge1)
               inv_d = {sign_q, e_res[EXP_BITS-1:0], {MAN_BITS{1'b0}}};
            else
               inv_d = {sign_q, e_res[EXP_BITS-1:0], y_d[IW-2 -: MAN_BITS]};
         end
      end

      assign inv_o[k*WIDTH +: WIDTH] = inv_q;
   end

endmodule

// File: tb/tb_sfm_acc_den_inverter_nr.sv
// Directed bench: 4-lane refined instance and 1-lane raw-seed instance.
module tb_sfm_acc_den_inverter_nr;

   logic clk = 1'b0;
   always #5 clk = ~clk;

   logic         rst;
   logic         a_clear, a_valid, a_ready, a_vo, a_ri;
   logic [127:0] a_den, a_inv;
   logic         b_clear, b_valid, b_ready, b_vo, b_ri;
   logic [31:0]  b_den, b_inv;

   int n_chk = 0;
   int n_err = 0;

   sfm_acc_den_inverter_nr #(
      .FPFORMAT (0),
      .NUM_LANES(4),
      .NUM_ITER (4)
   ) u_dut_a (
      .clk_i  (clk),
      .rst_i  (rst),
      .clear_i(a_clear),
      .valid_i(a_valid),
      .ready_o(a_ready),
      .den_i  (a_den),
      .valid_o(a_vo),
      .ready_i(a_ri),
      .inv_o  (a_inv)
   );

   sfm_acc_den_inverter_nr #(
      .FPFORMAT   (0),
      .NUM_LANES  (1),
      .N_SEED_BITS(4),
      .NUM_ITER   (0)
   ) u_dut_b (
      .clk_i  (clk),
      .rst_i  (rst),
      .clear_i(b_clear),
      .valid_i(b_valid),
      .ready_o(b_ready),
      .den_i  (b_den),
      .valid_o(b_vo),
      .ready_i(b_ri),
      .inv_o  (b_inv)
   );

   task automatic check(input string tag, input logic [127:0] obs, input logic [127:0] want);
      n_chk++;
      if (obs !== want) begin
         n_err++;
         $display("FAIL %s: got %h want %h", tag, obs, want);
      end
   endtask

   task automatic run_a(input logic [127:0] den, output logic [127:0] res, output int lat);
      @(negedge clk);
      a_den   = den;
      a_valid = 1'b1;
      lat     = 0;
      do begin
         @(posedge clk); #1;
         lat++;
         a_valid = 1'b0;
      end while (!a_vo && lat < 40);
      res = a_inv;
   endtask

   task automatic txn_a(input string tag, input logic [127:0] den, input logic [127:0] want);
      logic [127:0] res;
      int           lat;
      run_a(den, res, lat);
      check({tag, "_lat"}, 128'(lat), 128'd10);
      check({tag, "_inv"}, res, want);
      @(posedge clk); #1;
      check({tag, "_rdy"}, {126'd0, a_ready, a_vo}, 128'd2);
   endtask

   task automatic txn_b(input string tag, input logic [31:0] den, input logic [31:0] want);
      int lat;
      @(negedge clk);
      b_den   = den;
      b_valid = 1'b1;
      lat     = 0;
      do begin
         @(posedge clk); #1;
         lat++;
         b_valid = 1'b0;
      end while (!b_vo && lat < 40);
      check({tag, "_lat"}, 128'(lat), 128'd2);
      check({tag, "_inv"}, {96'd0, b_inv}, {96'd0, want});
      @(posedge clk); #1;
   endtask

   function automatic logic in_rng(input logic [31:0] v, input logic [31:0] lo, input logic [31:0] hi);
      return (v >= lo) && (v <= hi);
   endfunction

   localparam logic [127:0] P2_DEN  = {32'h40800000, 32'h3F000000, 32'hC1000000, 32'h40000000};
   localparam logic [127:0] P2_WANT = {32'h3E800000, 32'h40000000, 32'hBE000000, 32'h3F000000};
   localparam logic [127:0] SP_DEN  = {32'h7FC00001, 32'h7F800000, 32'h80000000, 32'h00000000};
   localparam logic [127:0] SP_WANT = {32'h7FC00000, 32'h00000000, 32'hFF800000, 32'h7F800000};

   initial begin
      logic [127:0] res;
      int           lat;
      logic         seen;

      rst = 1'b1;
      a_clear = 1'b0; a_valid = 1'b0; a_den = '0; a_ri = 1'b1;
      b_clear = 1'b0; b_valid = 1'b0; b_den = '0; b_ri = 1'b1;
      #12;
      check("rst_a_hs",  {126'd0, a_ready, a_vo}, 128'd2);
      check("rst_a_inv", a_inv, 128'd0);
      check("rst_b_hs",  {126'd0, b_ready, b_vo}, 128'd2);
      check("rst_b_inv", {96'd0, b_inv}, 128'd0);
      @(negedge clk);
      rst = 1'b0;

      txn_a("pow2", P2_DEN, P2_WANT);
      txn_a("spec", SP_DEN, SP_WANT);
      txn_a("uflow", {32'hFF800000, 32'h00400000, 32'hFF000000, 32'h7F000000},
                     {32'h80000000, 32'h7F800000, 32'h80000000, 32'h00000000});

      // lanes: 3.0, 1.5, 5.0, 1.0
      run_a({32'h3F800000, 32'h40A00000, 32'h3FC00000, 32'h40400000}, res, lat);
      check("rng_lat", 128'(lat), 128'd10);
      check("rng_3p0", {127'd0, in_rng(res[31:0],  32'h3EAAAAA7, 32'h3EAAAAAB)}, 128'd1);
      check("rng_1p5", {127'd0, in_rng(res[63:32], 32'h3F2AAAA6, 32'h3F2AAAAA)}, 128'd1);
      check("rng_5p0", {127'd0, in_rng(res[95:64], 32'h3E4CCCC8, 32'h3E4CCCCC)}, 128'd1);
      check("rng_1p0", {96'd0, res[127:96]}, {96'd0, 32'h3F800000});
      @(posedge clk); #1;

      a_ri = 1'b0;
      run_a(P2_DEN, res, lat);
      check("bp_lat", 128'(lat), 128'd10);
      for (int i = 0; i < 5; i++) begin
         @(posedge clk); #1;
         check("bp_vo",  {127'd0, a_vo}, 128'd1);
         check("bp_inv", a_inv, P2_WANT);
      end
      @(negedge clk);
      a_ri = 1'b1;
      @(posedge clk); #1;
      check("bp_release", {126'd0, a_ready, a_vo}, 128'd2);

      @(negedge clk);
      a_valid = 1'b1;
      a_clear = 1'b1;
      @(posedge clk); #1;
      a_valid = 1'b0;
      a_clear = 1'b0;
      check("clr_vs_valid", {126'd0, a_ready, a_vo}, 128'd2);

      @(negedge clk);
      a_den   = P2_DEN;
      a_valid = 1'b1;
      for (int i = 0; i < 5; i++) begin
         @(posedge clk); #1;
         a_valid = 1'b0;
      end
      check("abort_busy", {127'd0, a_ready}, 128'd0);
      a_clear = 1'b1;
      @(posedge clk); #1;
      a_clear = 1'b0;
      check("abort_idle", {126'd0, a_ready, a_vo}, 128'd2);
      seen = 1'b0;
      for (int i = 0; i < 14; i++) begin
         @(posedge clk); #1;
         if (a_vo) seen = 1'b1;
      end
      check("abort_novalid", {127'd0, seen}, 128'd0);
      txn_a("after_abort", SP_DEN, SP_WANT);

      txn_b("seed_3p0",  32'h40400000, 32'h3E900000);
      txn_b("seed_2p5",  32'h40200000, 32'h3EB00000);
      txn_b("seed_3p75", 32'h40700000, 32'h3E800000);
      txn_b("seed_1p0",  32'h3F800000, 32'h3F800000);

      @(negedge clk);
      a_den   = P2_DEN;
      a_valid = 1'b1;
      for (int i = 0; i < 4; i++) begin
         @(posedge clk); #1;
         a_valid = 1'b0;
      end
      #2;
      check("arst_busy", {127'd0, a_ready}, 128'd0);
      rst = 1'b1;
      #1;
      check("arst_hs",  {126'd0, a_ready, a_vo}, 128'd2);
      check("arst_inv", a_inv, 128'd0);
      @(negedge clk);
      rst = 1'b0;
      txn_a("post_rst", P2_DEN, P2_WANT);

      $display("Result: errors=%0d of %0d checks", n_err, n_chk);
      $finish;
   end

   initial begin
      #100000;
      $display("FAIL watchdog: simulation did not complete, errors=%0d checks=%0d", n_err, n_chk);
      $fatal(1);
   end

endmodule
